adc_fifo_writer: RTL and testbench
==================================

# adc_fifo_writer

Acquisition front end of the echo receive path. It paces the external parallel ADC from the 50 MHz system clock, discards the ADC's pipeline-flush samples, and writes a fixed-length burst of 12-bit samples into the dual-clock sample FIFO, one single-cycle write request per sample period. The echo correlation stage drains that FIFO. Its time-of-flight result is a sample index, so this block must keep one FIFO slot or one counted drop per sample period and never skip silently.

## Interface
- `SAMPLE_DIV`, 50: system clocks per ADC sample (1 MHz at 50 MHz); legal range 4..63.
- `NUM_SAMPLES`, 20000: samples per capture burst; legal range 1..2^SAMPLE_W−1.
- `ADC_LATENCY`, 2: ADC pipeline depth, in sample strobes, discarded after start; legal range 0..7.
- `SAMPLE_W`, 15: width of the sample counter.

Ports (clock and reset first):
- `clk_50M`  in  1  system clock. The only clock in this block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sys_start_pulse`  in  1  one-cycle capture start; same pulse the correlator receives.
- `adc_data`  in  12  ADC parallel output, stable around the sample strobe.
- `adc_clk`  out  1  ADC conversion clock, generated from the divider.
- `fifo_data`  out  12  sample to the FIFO `data` input.
- `fifo_wrreq`  out  1  FIFO write request, one cycle per sample.
- `fifo_wrfull`  in  1  FIFO write-side full flag.
- `capture_busy`  out  1  high in FLUSH and CAPTURE.
- `capture_done`  out  1  one-cycle pulse at end of burst.
- `overflow_flag`  out  1  sticky; set when a sample is dropped because the FIFO is full.
- `sample_count`  out  SAMPLE_W  samples handled in the current burst.

## Operation
- States: IDLE, FLUSH, CAPTURE, DONE. Reset returns to IDLE.
- IDLE, on `sys_start_pulse`:
  - go to FLUSH;
  - clear `div_cnt`, `sample_count` and `overflow_flag`.
- `div_cnt` counts 0..SAMPLE_DIV−1 and wraps. It runs only in FLUSH and CAPTURE and is held at 0 otherwise.
- `adc_clk` = 1 when `div_cnt` < SAMPLE_DIV/2 (integer division) and state is FLUSH or CAPTURE; 0 otherwise.
- Sample strobe `stb` = (`div_cnt` == SAMPLE_DIV−1).
- FLUSH:
  - count ADC_LATENCY strobes, then move to CAPTURE;
  - with ADC_LATENCY = 0, go to CAPTURE on the cycle after start;
  - no writes occur in FLUSH.
- CAPTURE, on each `stb`:
  - register `adc_data` into `fifo_data`;
  - on the next cycle, assert `fifo_wrreq` = !`fifo_wrfull`, sampling `fifo_wrfull` in the strobe cycle;
  - if full: no write, `overflow_flag` is set, and the sample is still counted;
  - `sample_count` increments in the strobe cycle.
- When `sample_count` reaches NUM_SAMPLES, go to DONE. DONE lasts one cycle with `capture_done` = 1, then the block returns to IDLE.
- `sys_start_pulse` is ignored outside IDLE. `adc_data` is ignored outside CAPTURE strobes.
- Arithmetic is unsigned. `sample_count` never exceeds NUM_SAMPLES.

## Timing
- Reset value 0 on every output, including `fifo_data`.
- Start sampled at edge T:
  - `capture_busy` rises at T+1;
  - the first strobe is in cycle T+SAMPLE_DIV;
  - the first `fifo_wrreq` is in cycle T+(ADC_LATENCY+1)·SAMPLE_DIV+1.
- Write latency: `fifo_data` and `fifo_wrreq` are valid exactly 1 cycle after the strobe. `fifo_data` holds until the next strobe.
- Spacing between consecutive `fifo_wrreq` pulses is exactly SAMPLE_DIV cycles. There are never two consecutive high cycles.
- Last strobe at cycle S:
  - DONE and `capture_done` in cycle S+1, coincident with the last `fifo_wrreq`;
  - `capture_busy` low from S+1.
- `fifo_wrfull` is sampled only in strobe cycles. A deassertion between strobes has no effect on the pending decision.
- `rst_n` low mid-burst:
  - immediate async clear, with no write and no done pulse;
  - the next start runs a full flush again.
- Start coincident with DONE: ignored. A new burst requires a start while in IDLE.

## Structure
- Shared package `us_acq_pkg`:
  - state enum (IDLE/FLUSH/CAPTURE/DONE);
  - `ADC_W` = 12;
  - default SAMPLE_DIV, NUM_SAMPLES and ADC_LATENCY constants, also used by the correlator bench.
- One sub-module, `adc_rate_gen`:
  - contains `div_cnt`, `adc_clk` and `stb`;
  - has enable and synchronous clear inputs;
  - parameterised by SAMPLE_DIV.

## Test plan
- SAMPLE_DIV=4, NUM_SAMPLES=4, ADC_LATENCY=2, ramp `adc_data` = strobe index, start at T:
  - writes carry 2,3,4,5 at T+13, 17, 21, 25;
  - `capture_done` at T+25;
  - `sample_count`=4.
- Defaults (50/20000/2), counting `wrreq` pulses:
  - exactly 20000 pulses, spaced 50 cycles apart;
  - `adc_clk` high for 25 cycles and low for 25;
  - `overflow_flag`=0.
- Force `fifo_wrfull`=1 for strobes 1–2 of a 4-sample burst:
  - only 2 writes;
  - `overflow_flag`=1 and held through IDLE;
  - `sample_count`=4;
  - flag cleared by the next start.
- Start pulses repeated every 3 cycles during a burst:
  - no restart;
  - `sample_count` and write timing identical to the single-start run.
- `rst_n` pulsed low in CAPTURE after 2 writes:
  - all outputs 0 immediately;
  - a new start yields a full 4-sample burst with flush.
- ADC_LATENCY=0, SAMPLE_DIV=5:
  - the first write carries strobe-0 data at T+6;
  - `adc_clk` high for 2 of every 5 cycles.

Source files
------------

// File: rtl/us_acq_pkg.sv
// Shared acquisition definitions for the echo receive path (ADC front end and correlator bench).
package us_acq_pkg;

  localparam int unsigned ADC_W           = 12;
  localparam int unsigned DEF_SAMPLE_DIV  = 50;
  localparam int unsigned DEF_NUM_SAMPLES = 20000;
  localparam int unsigned DEF_ADC_LATENCY = 2;
  localparam int unsigned DEF_SAMPLE_W    = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } acq_state_t;

endpackage

// File: rtl/adc_rate_gen.sv
// Sample-rate divider: produces the ADC conversion clock and a one-cycle sample strobe.
module adc_rate_gen
  import us_acq_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic adc_clk,
  output logic stb
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SAMPLE_DIV / 2);

  logic [CNT_W-1:0] div_cnt;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= (div_cnt == CNT_LAST) ? '0 : div_cnt + CNT_W'(1);
    end
  end

  // High for the first half of each sample period, low outside a capture.
  assign adc_clk = en && (div_cnt < CNT_HALF);
  assign stb     = en && (div_cnt == CNT_LAST);

endmodule

// File: rtl/adc_fifo_writer.sv
// ADC acquisition front end: paces the ADC, drops pipeline-flush samples and writes
// one FIFO slot (or one counted overflow) per sample period for a fixed-length burst.
module adc_fifo_writer
  import us_acq_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV  = DEF_SAMPLE_DIV,
  parameter int unsigned NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int unsigned ADC_LATENCY = DEF_ADC_LATENCY,
  parameter int unsigned SAMPLE_W    = DEF_SAMPLE_W
) (
  input  logic                clk_50M,
  input  logic                rst_n,
  input  logic                sys_start_pulse,
  input  logic [ADC_W-1:0]    adc_data,
  output logic                adc_clk,
  output logic [ADC_W-1:0]    fifo_data,
  output logic                fifo_wrreq,
  input  logic                fifo_wrfull,
  output logic                capture_busy,
  output logic                capture_done,
  output logic                overflow_flag,
  output logic [SAMPLE_W-1:0] sample_count
);

  localparam logic [SAMPLE_W-1:0] LAST_IDX   = SAMPLE_W'(NUM_SAMPLES - 1);
  localparam logic [2:0]          FLUSH_LAST = 3'((ADC_LATENCY == 0) ? 0 : ADC_LATENCY - 1);

  acq_state_t state, state_nx;
  logic [2:0] flush_cnt;
  logic       stb;
  logic       cap_stb;
  logic       start_ok;

  assign capture_busy = (state == FLUSH) || (state == CAPTURE);
  assign capture_done = (state == DONE);
  assign start_ok     = (state == IDLE) && sys_start_pulse;
  assign cap_stb      = (state == CAPTURE) && stb;

  // Divider runs through FLUSH into CAPTURE without a restart, so sample spacing stays uniform.
  adc_rate_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_rate_gen (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .en      (capture_busy),
    .clr     (!capture_busy),
    .adc_clk (adc_clk),
    .stb     (stb)
  );

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (sys_start_pulse) state_nx = FLUSH;
      end
      FLUSH: begin
        if ((ADC_LATENCY == 0) || (stb && (flush_cnt == FLUSH_LAST))) state_nx = CAPTURE;
      end
      CAPTURE: begin
        if (stb && (sample_count == LAST_IDX)) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt     <= '0;
      sample_count  <= '0;
      overflow_flag <= 1'b0;
      fifo_data     <= '0;
      fifo_wrreq    <= 1'b0;
    end else begin
      // Full is judged only at the strobe; a dropped sample still consumes its index.
      fifo_wrreq <= cap_stb && !fifo_wrfull;

      if (state != FLUSH) begin
        flush_cnt <= '0;
      end else if (stb) begin
        flush_cnt <= flush_cnt + 3'd1;
      end

      if (start_ok) begin
        sample_count  <= '0;
        overflow_flag <= 1'b0;
      end

      if (cap_stb) begin
        fifo_data    <= adc_data;
        sample_count <= sample_count + SAMPLE_W'(1);
        if (fifo_wrfull) overflow_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_fifo_writer.sv
// Directed bench for adc_fifo_writer: three parameterisations driven one at a time.
module tb_adc_fifo_writer;

  typedef struct {
    int          off;
    logic        wr;
    logic [11:0] dat;
    logic        busy;
    logic        done;
    logic        aclk;
    int          cnt;
    logic        ovf;
  } vec_t;

  logic        clk_50M = 1'b0;
  logic        rst_n;
  logic [2:0]  start;
  logic [2:0]  full;
  logic [11:0] adin [3];
  logic [11:0] dq   [3];
  logic [14:0] cnt  [3];
  logic [2:0]  wr, aclk, busy, done, ovf;

  int checks = 0;
  int errors = 0;

  int divs [3] = '{4, 50, 5};
  int off, last_p, consec, bad_space, bad_run, hi_cyc, busy_cyc, hi_run, lo_run, done_off;
  bit prev_wr, done_seen;
  int pulses [$];
  int pdat   [$];
  vec_t tv [13];

  always #5 clk_50M = ~clk_50M;

  adc_fifo_writer #(.SAMPLE_DIV(4), .NUM_SAMPLES(4), .ADC_LATENCY(2), .SAMPLE_W(15)) u_a (
    .clk_50M(clk_50M), .rst_n(rst_n), .sys_start_pulse(start[0]), .adc_data(adin[0]),
    .adc_clk(aclk[0]), .fifo_data(dq[0]), .fifo_wrreq(wr[0]), .fifo_wrfull(full[0]),
    .capture_busy(busy[0]), .capture_done(done[0]), .overflow_flag(ovf[0]), .sample_count(cnt[0])
  );

  adc_fifo_writer #(.SAMPLE_DIV(50), .NUM_SAMPLES(400), .ADC_LATENCY(2), .SAMPLE_W(15)) u_b (
    .clk_50M(clk_50M), .rst_n(rst_n), .sys_start_pulse(start[1]), .adc_data(adin[1]),
    .adc_clk(aclk[1]), .fifo_data(dq[1]), .fifo_wrreq(wr[1]), .fifo_wrfull(full[1]),
    .capture_busy(busy[1]), .capture_done(done[1]), .overflow_flag(ovf[1]), .sample_count(cnt[1])
  );

  adc_fifo_writer #(.SAMPLE_DIV(5), .NUM_SAMPLES(3), .ADC_LATENCY(0), .SAMPLE_W(15)) u_c (
    .clk_50M(clk_50M), .rst_n(rst_n), .sys_start_pulse(start[2]), .adc_data(adin[2]),
    .adc_clk(aclk[2]), .fifo_data(dq[2]), .fifo_wrreq(wr[2]), .fifo_wrfull(full[2]),
    .capture_busy(busy[2]), .capture_done(done[2]), .overflow_flag(ovf[2]), .sample_count(cnt[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_stats();
    off = -1; last_p = -1; consec = 0; bad_space = 0; bad_run = 0;
    hi_cyc = 0; busy_cyc = 0; hi_run = 0; lo_run = 0; done_off = -1;
    prev_wr = 1'b0; done_seen = 1'b0;
    pulses.delete();
    pdat.delete();
  endtask

  // mode 0: single start, 1: start every 3 cycles (and on DONE), 2: full pattern, 3: no start
  task automatic step(input int id, input int mode);
    bit st, fl;
    @(posedge clk_50M);
    off++;
    #1;
    case (mode)
      0, 2:    st = (off == 0);
      1:       st = ((off <= 24) && (off % 3 == 0)) || (off == 25);
      default: st = 1'b0;
    endcase
    fl = (mode == 2) && ((off <= 12) || off == 15 || off == 16 || off == 18 || off == 19);
    start = '0;
    full  = '0;
    start[id] = st;
    full[id]  = fl;
    adin[0] = 12'((off >= 4) ? off / 4 - 1 : 0);
    adin[1] = 12'(off);
    adin[2] = 12'((off >= 5) ? 'hA50 + off / 5 - 1 : 0);
    @(negedge clk_50M);
    if (wr[id]) begin
      pulses.push_back(off);
      pdat.push_back(int'(dq[id]));
      if (last_p >= 0 && off - last_p != divs[id]) bad_space++;
      last_p = off;
    end
    if (wr[id] && prev_wr) consec++;
    prev_wr = wr[id];
    if (done[id]) begin
      done_seen = 1'b1;
      done_off  = off;
    end
    if (busy[id]) busy_cyc++;
    if (aclk[id] && !busy[id]) bad_run++;
    if (aclk[id]) begin
      hi_cyc++;
      if (lo_run != 0 && lo_run != divs[id] - divs[id] / 2) bad_run++;
      lo_run = 0;
      hi_run++;
    end else begin
      if (hi_run != 0 && hi_run != divs[id] / 2) bad_run++;
      hi_run = 0;
      if (busy[id]) lo_run++;
    end
  endtask

  task automatic run_until(input int id, input int mode, input int target);
    while (off < target) step(id, mode);
  endtask

  task automatic check_writes(input string tag, input int n, input int e_off [4], input int e_dat [4]);
    check({tag, "_nwr"}, 32'(pulses.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_wr%0d_cyc", tag, i), 32'((i < pulses.size()) ? pulses[i] : -1), 32'(e_off[i]));
      check($sformatf("%s_wr%0d_dat", tag, i), 32'((i < pdat.size()) ? pdat[i] : -1), 32'(e_dat[i]));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        off wr dat busy done aclk cnt ovf
    tv[0]  = '{0,  0, 0,  0,   0,   0,   0,  0};
    tv[1]  = '{1,  0, 0,  1,   0,   1,   0,  0};
    tv[2]  = '{3,  0, 0,  1,   0,   0,   0,  0};
    tv[3]  = '{4,  0, 0,  1,   0,   0,   0,  0};
    tv[4]  = '{5,  0, 0,  1,   0,   1,   0,  0};
    tv[5]  = '{12, 0, 0,  1,   0,   0,   0,  0};
    tv[6]  = '{13, 1, 2,  1,   0,   1,   1,  0};
    tv[7]  = '{14, 0, 2,  1,   0,   1,   1,  0};
    tv[8]  = '{17, 1, 3,  1,   0,   1,   2,  0};
    tv[9]  = '{21, 1, 4,  1,   0,   1,   3,  0};
    tv[10] = '{24, 0, 4,  1,   0,   0,   3,  0};
    tv[11] = '{25, 1, 5,  0,   1,   0,   4,  0};
    tv[12] = '{26, 0, 5,  0,   0,   0,   4,  0};

    rst_n = 1'b0;
    start = '0;
    full  = '0;
    for (int i = 0; i < 3; i++) adin[i] = '0;
    repeat (3) @(negedge clk_50M);
    check("rst_wrreq", 32'(wr[0]), 0);
    check("rst_data",  32'(dq[0]), 0);
    check("rst_busy",  32'(busy[0]), 0);
    check("rst_done",  32'(done[0]), 0);
    check("rst_aclk",  32'(aclk[0]), 0);
    check("rst_ovf",   32'(ovf[0]), 0);
    check("rst_count", 32'(cnt[0]), 0);
    rst_n = 1'b1;

    // Basic burst, table-driven
    reset_stats();
    for (int i = 0; i < 13; i++) begin
      run_until(0, 0, tv[i].off);
      check($sformatf("t%0d_wrreq", tv[i].off), 32'(wr[0]),   32'(tv[i].wr));
      check($sformatf("t%0d_data",  tv[i].off), 32'(dq[0]),   32'(tv[i].dat));
      check($sformatf("t%0d_busy",  tv[i].off), 32'(busy[0]), 32'(tv[i].busy));
      check($sformatf("t%0d_done",  tv[i].off), 32'(done[0]), 32'(tv[i].done));
      check($sformatf("t%0d_aclk",  tv[i].off), 32'(aclk[0]), 32'(tv[i].aclk));
      check($sformatf("t%0d_count", tv[i].off), 32'(cnt[0]),  32'(tv[i].cnt));
      check($sformatf("t%0d_ovf",   tv[i].off), 32'(ovf[0]),  32'(tv[i].ovf));
    end
    run_until(0, 0, 30);
    check_writes("basic", 4, '{13, 17, 21, 25}, '{2, 3, 4, 5});
    check("basic_idle_busy", 32'(busy[0]), 0);
    check("basic_spacing", 32'(bad_space), 0);
    check("basic_consec", 32'(consec), 0);
    check("basic_aclk_runs", 32'(bad_run), 0);

    // Repeated starts during the burst, including one coincident with DONE
    reset_stats();
    run_until(0, 1, 30);
    check_writes("restart", 4, '{13, 17, 21, 25}, '{2, 3, 4, 5});
    check("restart_done_cyc", 32'(done_off), 25);
    check("restart_count", 32'(cnt[0]), 4);
    check("restart_idle_busy", 32'(busy[0]), 0);

    // Full on the first two capture strobes, with full glitches between strobes
    reset_stats();
    run_until(0, 2, 12);
    check("ovf_before", 32'(ovf[0]), 0);
    step(0, 2);
    check("ovf_set", 32'(ovf[0]), 1);
    check("ovf_nowrite", 32'(wr[0]), 0);
    run_until(0, 2, 35);
    check_writes("ovf", 2, '{21, 25, 0, 0}, '{4, 5, 0, 0});
    check("ovf_count", 32'(cnt[0]), 4);
    check("ovf_held_idle", 32'(ovf[0]), 1);
    check("ovf_idle_busy", 32'(busy[0]), 0);

    // Next start clears the sticky flag
    reset_stats();
    step(0, 0);
    check("ovf_kept_start_cyc", 32'(ovf[0]), 1);
    step(0, 0);
    check("ovf_cleared", 32'(ovf[0]), 0);
    check("count_cleared", 32'(cnt[0]), 0);
    run_until(0, 0, 30);
    check_writes("after_ovf", 4, '{13, 17, 21, 25}, '{2, 3, 4, 5});

    // Asynchronous reset mid-capture after two writes
    reset_stats();
    run_until(0, 0, 19);
    check("pre_rst_count", 32'(cnt[0]), 2);
    @(posedge clk_50M);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wrreq", 32'(wr[0]), 0);
    check("mid_rst_data",  32'(dq[0]), 0);
    check("mid_rst_busy",  32'(busy[0]), 0);
    check("mid_rst_done",  32'(done[0]), 0);
    check("mid_rst_aclk",  32'(aclk[0]), 0);
    check("mid_rst_ovf",   32'(ovf[0]), 0);
    check("mid_rst_count", 32'(cnt[0]), 0);
    repeat (3) @(negedge clk_50M);
    check("rst_hold_wrreq", 32'(wr[0]), 0);
    rst_n = 1'b1;
    reset_stats();
    run_until(0, 0, 30);
    check_writes("post_rst", 4, '{13, 17, 21, 25}, '{2, 3, 4, 5});
    check("post_rst_done_cyc", 32'(done_off), 25);
    check("post_rst_count", 32'(cnt[0]), 4);

    // Default pacing (50 clocks, latency 2) over a 400-sample burst
    reset_stats();
    while (!done_seen && off < 21000) step(1, 0);
    check("long_done_seen", 32'(done_seen), 1);
    repeat (3) step(1, 3);
    check("long_nwr", 32'(pulses.size()), 400);
    check("long_first_wr", 32'((pulses.size() > 0) ? pulses[0] : -1), 151);
    check("long_done_cyc", 32'(done_off), 151 + 399 * 50);
    check("long_spacing", 32'(bad_space), 0);
    check("long_consec", 32'(consec), 0);
    check("long_aclk_runs", 32'(bad_run), 0);
    check("long_aclk_high", 32'(hi_cyc), 402 * 25);
    check("long_busy_cyc", 32'(busy_cyc), 402 * 50);
    check("long_ovf", 32'(ovf[1]), 0);
    check("long_count", 32'(cnt[1]), 400);

    // Zero ADC latency, 5-clock sample period
    reset_stats();
    run_until(2, 0, 20);
    check_writes("nolat", 3, '{6, 11, 16, 0}, '{'hA50, 'hA51, 'hA52, 0});
    check("nolat_done_cyc", 32'(done_off), 16);
    check("nolat_aclk_high", 32'(hi_cyc), 6);
    check("nolat_busy_cyc", 32'(busy_cyc), 15);
    check("nolat_aclk_runs", 32'(bad_run), 0);
    check("nolat_count", 32'(cnt[2]), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
